// File: rtl/uarc_bus_if.sv
// Sender-to-receiver lines of one UARC core-to-core bus: request/acknowledge
// handshakes plus the data, permission and address words.
interface uarc_bus_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             enabled;
    logic             kill;
    logic             kill_ack;
    logic             incept;
    logic             incept_ack;
    logic             send;
    logic             send_ack;
    logic             stream;
    logic             stream_ack;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] incept_permission;
    logic [WIDTH-1:0] incept_address;

    modport master (
        output enabled, kill, incept, send, stream,
        output data, incept_permission, incept_address,
        input  kill_ack, incept_ack, send_ack, stream_ack
    );

    modport slave (
        input  enabled, kill, incept, send, stream,
        input  data, incept_permission, incept_address,
        output kill_ack, incept_ack, send_ack, stream_ack
    );
endinterface

// File: rtl/uarc_bus_receiver.sv
// Receiving endpoint of a UARC core-to-core bus: answers kill/incept/send/stream,
// loads incepted programs into program memory and queues sent/streamed words.
module uarc_bus_receiver #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PROG_AW    = 10,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    uarc_bus_if.slave          bus,
    input  logic               core_busy,
    output logic               core_kill,
    output logic               prog_we,
    output logic [PROG_AW-1:0] prog_waddr,
    output logic [WIDTH-1:0]   prog_wdata,
    output logic               prog_start,
    output logic [WIDTH-1:0]   prog_start_address,
    output logic [WIDTH-1:0]   prog_permission,
    output logic               incept_error,
    output logic               rx_valid,
    output logic [WIDTH-1:0]   rx_data,
    output logic               rx_is_stream,
    input  logic               rx_ready
);
    localparam int unsigned CNT_W  = PROG_AW + 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = {1'b1, {PROG_AW{1'b0}}};
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_KILL   = 2'd1;
    localparam logic [1:0] ST_INCEPT = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              kill_seen_q, kill_seen_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              prog_start_q, prog_start_d;
    logic              incept_error_q, incept_error_d;
    logic [WIDTH-1:0]  start_addr_q, start_addr_d;
    logic [WIDTH-1:0]  perm_q, perm_d;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [WIDTH-1:0]  data_mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0]  data_mem_d [FIFO_DEPTH];
    logic              tag_mem_q  [FIFO_DEPTH];
    logic              tag_mem_d  [FIFO_DEPTH];

    logic req_kill, req_incept, req_send, req_stream;
    logic kill_go, flush, fifo_full, fifo_empty;
    logic send_ack_c, stream_ack_c, push, pop, xfer;

    // Request qualification and handshake decode
    always_comb begin
        req_kill     = bus.enabled & bus.kill;
        req_incept   = bus.enabled & bus.incept;
        req_send     = bus.enabled & bus.send;
        req_stream   = bus.enabled & bus.stream;
        kill_go      = req_kill & ~kill_seen_q;
        fifo_full    = (fcnt_q == FIFO_FULL);
        fifo_empty   = (fcnt_q == '0);
        send_ack_c   = (state_q == ST_IDLE) & req_send & ~req_kill & ~req_incept
                       & ~req_stream & ~fifo_full;
        stream_ack_c = (state_q == ST_STREAM) & bus.enabled & ~fifo_full;
        push         = send_ack_c | (bus.stream & stream_ack_c);
        pop          = ~fifo_empty & rx_ready;
        xfer         = (state_q == ST_INCEPT) & req_incept;
    end

    // Control FSM: kill preempts every state; incept outcome pulses on exit
    always_comb begin
        state_d        = state_q;
        kill_seen_d    = kill_seen_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        prog_start_d   = 1'b0;
        incept_error_d = 1'b0;
        start_addr_d   = start_addr_q;
        perm_d         = perm_q;
        flush          = 1'b0;

        // A held kill is acknowledged once; re-arm only after it is seen low
        if (!req_kill) begin
            kill_seen_d = 1'b0;
        end

        if (kill_go) begin
            state_d     = ST_KILL;
            kill_seen_d = 1'b1;
            flush       = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_incept && !core_busy && !req_kill) begin
                        state_d = ST_INCEPT;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else if (req_stream && !req_kill && !req_incept) begin
                        state_d = ST_STREAM;
                    end
                end
                ST_KILL: begin
                    state_d = ST_IDLE;
                end
                ST_INCEPT: begin
                    if (req_incept) begin
                        if (cnt_q == '0) begin
                            start_addr_d = bus.incept_address;
                            perm_d       = bus.incept_permission;
                        end
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        if (ovf_q) begin
                            incept_error_d = 1'b1;
                        end else if (cnt_q != '0) begin
                            prog_start_d = 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (!req_stream) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Receive FIFO; a kill flush overrides any push/pop on the same edge
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fcnt_d     = fcnt_q;
        data_mem_d = data_mem_q;
        tag_mem_d  = tag_mem_q;

        if (push) begin
            data_mem_d[wr_ptr_q] = bus.data;
            tag_mem_d[wr_ptr_q]  = (state_q == ST_STREAM);
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
            2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
            default: fcnt_d = fcnt_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fcnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            kill_seen_q    <= 1'b0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            prog_start_q   <= 1'b0;
            incept_error_q <= 1'b0;
            start_addr_q   <= '0;
            perm_q         <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fcnt_q         <= '0;
        end else begin
            state_q        <= state_d;
            kill_seen_q    <= kill_seen_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            prog_start_q   <= prog_start_d;
            incept_error_q <= incept_error_d;
            start_addr_q   <= start_addr_d;
            perm_q         <= perm_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fcnt_q         <= fcnt_d;
        end
    end

    // Storage needs no reset: the occupancy count masks stale entries
    always_ff @(posedge clk) begin
        data_mem_q <= data_mem_d;
        tag_mem_q  <= tag_mem_d;
    end

    assign bus.kill_ack   = (state_q == ST_KILL);
    assign bus.incept_ack = (state_q == ST_INCEPT);
    assign bus.send_ack   = send_ack_c;
    assign bus.stream_ack = stream_ack_c;

    assign core_kill          = (state_q == ST_KILL);
    assign prog_we            = xfer & (cnt_q != CNT_MAX);
    assign prog_waddr         = prog_we ? cnt_q[PROG_AW-1:0] : '0;
    assign prog_wdata         = prog_we ? bus.data : '0;
    assign prog_start         = prog_start_q;
    assign prog_start_address = start_addr_q;
    assign prog_permission    = perm_q;
    assign incept_error       = incept_error_q;
    assign rx_valid           = ~fifo_empty;
    assign rx_data            = fifo_empty ? '0 : data_mem_q[rd_ptr_q];
    assign rx_is_stream       = ~fifo_empty & tag_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_uarc_bus_receiver.sv
// Scoreboard bench for uarc_bus_receiver: stimulus queues expectations, a
// negedge monitor compares program writes, start/error pulses, FIFO pops and sampled values.
module tb_uarc_bus_receiver;
    localparam int unsigned WIDTH      = 32;
    localparam int unsigned PROG_AW    = 2;
    localparam int unsigned FIFO_DEPTH = 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               core_busy;
    logic               core_kill;
    logic               prog_we;
    logic [PROG_AW-1:0] prog_waddr;
    logic [WIDTH-1:0]   prog_wdata;
    logic               prog_start;
    logic [WIDTH-1:0]   prog_start_address;
    logic [WIDTH-1:0]   prog_permission;
    logic               incept_error;
    logic               rx_valid;
    logic [WIDTH-1:0]   rx_data;
    logic               rx_is_stream;
    logic               rx_ready;

    uarc_bus_if #(.WIDTH(WIDTH)) bus ();

    uarc_bus_receiver #(
        .WIDTH     (WIDTH),
        .PROG_AW   (PROG_AW),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .bus               (bus),
        .core_busy         (core_busy),
        .core_kill         (core_kill),
        .prog_we           (prog_we),
        .prog_waddr        (prog_waddr),
        .prog_wdata        (prog_wdata),
        .prog_start        (prog_start),
        .prog_start_address(prog_start_address),
        .prog_permission   (prog_permission),
        .incept_error      (incept_error),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .rx_is_stream      (rx_is_stream),
        .rx_ready          (rx_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [PROG_AW-1:0] addr; logic [WIDTH-1:0] data; } wr_t;
    typedef struct { logic [WIDTH-1:0] data; logic is_stream; } rx_t;
    typedef struct { logic [WIDTH-1:0] addr; logic [WIDTH-1:0] perm; } st_t;
    typedef struct { string name; logic [63:0] act; logic [63:0] exp; } chk_t;

    wr_t  wr_q[$];
    rx_t  rx_q[$];
    st_t  start_q[$];
    chk_t pend_q[$];
    int   err_exp = 0;
    int   n_checks = 0;
    int   n_fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        pend_q.push_back(c);
    endtask

    task automatic exp_wr(input logic [PROG_AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wr_q.push_back(e);
    endtask

    task automatic exp_rx(input logic [WIDTH-1:0] d, input logic s);
        rx_t e;
        e.data      = d;
        e.is_stream = s;
        rx_q.push_back(e);
    endtask

    task automatic exp_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] p);
        st_t e;
        e.addr = a;
        e.perm = p;
        start_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all_zero(input string tag);
        expect_eq({tag, "_ctrl"}, 64'({bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack,
                  core_kill, prog_we, prog_start, incept_error, rx_valid, rx_is_stream}), 64'd0);
        expect_eq({tag, "_waddr"}, 64'(prog_waddr), 64'd0);
        expect_eq({tag, "_wdata"}, 64'(prog_wdata), 64'd0);
        expect_eq({tag, "_start_addr"}, 64'(prog_start_address), 64'd0);
        expect_eq({tag, "_perm"}, 64'(prog_permission), 64'd0);
        expect_eq({tag, "_rx_data"}, 64'(rx_data), 64'd0);
    endtask

    // Monitor: every DUT event is matched against the head of its queue
    always @(negedge clk) begin
        wr_t  we;
        rx_t  re;
        st_t  se;
        chk_t c;
        if (reset_n === 1'b1) begin
            if (prog_we === 1'b1) begin
                chk("prog_write_expected", 64'(wr_q.size() > 0), 64'd1);
                if (wr_q.size() > 0) begin
                    we = wr_q.pop_front();
                    chk("prog_waddr", 64'(prog_waddr), 64'(we.addr));
                    chk("prog_wdata", 64'(prog_wdata), 64'(we.data));
                end
            end
            if (prog_start === 1'b1) begin
                chk("prog_start_expected", 64'(start_q.size() > 0), 64'd1);
                if (start_q.size() > 0) begin
                    se = start_q.pop_front();
                    chk("prog_start_address", 64'(prog_start_address), 64'(se.addr));
                    chk("prog_permission", 64'(prog_permission), 64'(se.perm));
                end
            end
            if (incept_error === 1'b1) begin
                chk("incept_error_expected", 64'(err_exp > 0), 64'd1);
                if (err_exp > 0) err_exp--;
            end
            if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
                chk("rx_pop_expected", 64'(rx_q.size() > 0), 64'd1);
                if (rx_q.size() > 0) begin
                    re = rx_q.pop_front();
                    chk("rx_data", 64'(rx_data), 64'(re.data));
                    chk("rx_is_stream", 64'(rx_is_stream), 64'(re.is_stream));
                end
            end
        end
        while (pend_q.size() > 0) begin
            c = pend_q.pop_front();
            chk(c.name, c.act, c.exp);
        end
    end

    initial begin
        repeat (3000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete within 3000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset_n                = 1'b0;
        core_busy              = 1'b0;
        rx_ready               = 1'b0;
        bus.enabled            = 1'b0;
        bus.kill               = 1'b0;
        bus.incept             = 1'b0;
        bus.send               = 1'b0;
        bus.stream             = 1'b0;
        bus.data               = '0;
        bus.incept_address     = '0;
        bus.incept_permission  = '0;
        repeat (3) next_cycle();
        @(negedge clk);
        expect_all_zero("reset");
        next_cycle();
        reset_n     = 1'b1;
        bus.enabled = 1'b1;
        next_cycle();

        // Incept of four words then start pulse
        bus.incept_address    = 32'h100;
        bus.incept_permission = 32'h7;
        bus.data              = 32'hA0;
        bus.incept            = 1'b1;
        for (int i = 0; i < 4; i++) exp_wr(PROG_AW'(i), 32'hA0 + 32'(i));
        @(negedge clk);
        expect_eq("incept_ack_req_cycle", 64'(bus.incept_ack), 64'd0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            bus.data = 32'hA0 + 32'(i);
            @(negedge clk);
            expect_eq("incept_ack_xfer", 64'(bus.incept_ack), 64'd1);
            next_cycle();
        end
        bus.incept = 1'b0;
        exp_start(32'h100, 32'h7);
        next_cycle();
        @(negedge clk);
        expect_eq("incept_ack_after_end", 64'(bus.incept_ack), 64'd0);
        next_cycle();
        next_cycle();
        expect_eq("incept1_start_consumed", 64'(start_q.size()), 64'd0);
        expect_eq("incept1_writes_consumed", 64'(wr_q.size()), 64'd0);

        // Send with same-cycle acknowledge
        bus.data = 32'h55;
        bus.send = 1'b1;
        @(negedge clk);
        expect_eq("send_ack_same_cycle", 64'(bus.send_ack), 64'd1);
        exp_rx(32'h55, 1'b0);
        next_cycle();
        bus.send = 1'b0;
        @(negedge clk);
        expect_eq("send_rx_valid", 64'(rx_valid), 64'd1);
        expect_eq("send_rx_data", 64'(rx_data), 64'h55);
        expect_eq("send_rx_is_stream", 64'(rx_is_stream), 64'd0);
        next_cycle();
        rx_ready = 1'b1;
        next_cycle();
        rx_ready = 1'b0;

        // Stream of ten words into an eight-entry FIFO
        bus.stream = 1'b1;
        bus.data   = 32'h1000;
        @(negedge clk);
        expect_eq("stream_ack_idle", 64'(bus.stream_ack), 64'd0);
        next_cycle();
        for (int c = 0; c < 8; c++) begin
            bus.data = 32'h1000 + 32'(c);
            @(negedge clk);
            expect_eq("stream_ack_fill", 64'(bus.stream_ack), 64'd1);
            exp_rx(32'h1000 + 32'(c), 1'b1);
            next_cycle();
        end
        bus.data = 32'h1008;
        @(negedge clk);
        expect_eq("stream_ack_full", 64'(bus.stream_ack), 64'd0);
        next_cycle();
        rx_ready = 1'b1;
        @(negedge clk);
        expect_eq("stream_ack_full_with_pop", 64'(bus.stream_ack), 64'd0);
        next_cycle();
        k = 8;
        for (int t = 0; t < 20 && k < 10; t++) begin
            bus.data = 32'h1000 + 32'(k);
            @(negedge clk);
            if (bus.stream_ack === 1'b1) begin
                exp_rx(32'h1000 + 32'(k), 1'b1);
                k++;
            end
            next_cycle();
        end
        expect_eq("stream_words_accepted", 64'(k), 64'd10);
        bus.stream = 1'b0;
        for (int t = 0; t < 20 && rx_valid === 1'b1; t++) next_cycle();
        expect_eq("stream_drained", 64'(rx_q.size()), 64'd0);
        rx_ready = 1'b0;
        next_cycle();

        // Kill on the third incept word with a word parked in the FIFO
        bus.data = 32'h77;
        bus.send = 1'b1;
        next_cycle();
        bus.send = 1'b0;
        @(negedge clk);
        expect_eq("kill_pre_fifo_valid", 64'(rx_valid), 64'd1);
        next_cycle();
        bus.incept_address    = 32'h180;
        bus.incept_permission = 32'h2;
        bus.data              = 32'hB0;
        bus.incept            = 1'b1;
        for (int i = 0; i < 3; i++) exp_wr(PROG_AW'(i), 32'hB0 + 32'(i));
        next_cycle();
        bus.data = 32'hB0;
        next_cycle();
        bus.data = 32'hB1;
        next_cycle();
        bus.data = 32'hB2;
        bus.kill = 1'b1;
        @(negedge clk);
        expect_eq("kill_req_cycle_ack", 64'(bus.kill_ack), 64'd0);
        next_cycle();
        bus.incept = 1'b0;
        @(negedge clk);
        expect_eq("kill_ack_pulse", 64'(bus.kill_ack), 64'd1);
        expect_eq("core_kill_pulse", 64'(core_kill), 64'd1);
        expect_eq("kill_flushes_fifo", 64'(rx_valid), 64'd0);
        expect_eq("kill_aborts_incept", 64'(bus.incept_ack), 64'd0);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_eq("kill_held_no_reack", 64'({bus.kill_ack, core_kill}), 64'd0);
            expect_eq("kill_no_start_or_error", 64'({prog_start, incept_error}), 64'd0);
            next_cycle();
        end
        bus.kill = 1'b0;
        next_cycle();
        expect_eq("kill_writes_consumed", 64'(wr_q.size()), 64'd0);

        // Incept refused while core busy; incept beats a simultaneous stream
        core_busy             = 1'b1;
        bus.incept            = 1'b1;
        bus.incept_address    = 32'h200;
        bus.incept_permission = 32'h3;
        bus.data              = 32'hC0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_eq("incept_refused_busy", 64'(bus.incept_ack), 64'd0);
            next_cycle();
        end
        core_busy  = 1'b0;
        bus.stream = 1'b1;
        @(negedge clk);
        expect_eq("priority_idle_stream_ack", 64'(bus.stream_ack), 64'd0);
        exp_wr(PROG_AW'(0), 32'hC0);
        next_cycle();
        @(negedge clk);
        expect_eq("priority_incept_wins", 64'(bus.incept_ack), 64'd1);
        expect_eq("priority_stream_loses", 64'(bus.stream_ack), 64'd0);
        next_cycle();
        bus.incept = 1'b0;
        bus.stream = 1'b0;
        exp_start(32'h200, 32'h3);
        next_cycle();
        next_cycle();
        next_cycle();
        expect_eq("priority_start_consumed", 64'(start_q.size()), 64'd0);

        // Overflow: five words into a four-word program space
        bus.incept_address    = 32'h300;
        bus.incept_permission = 32'h1;
        bus.data              = 32'hD0;
        bus.incept            = 1'b1;
        for (int i = 0; i < 4; i++) exp_wr(PROG_AW'(i), 32'hD0 + 32'(i));
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            bus.data = 32'hD0 + 32'(i);
            @(negedge clk);
            expect_eq("overflow_incept_ack", 64'(bus.incept_ack), 64'd1);
            next_cycle();
        end
        bus.incept = 1'b0;
        err_exp    = 1;
        next_cycle();
        next_cycle();
        next_cycle();
        expect_eq("overflow_error_seen", 64'(err_exp), 64'd0);
        expect_eq("overflow_writes_consumed", 64'(wr_q.size()), 64'd0);

        // Reset in the middle of a stream
        bus.stream = 1'b1;
        bus.data   = 32'hE0;
        next_cycle();
        next_cycle();
        bus.data = 32'hE1;
        next_cycle();
        @(negedge clk);
        expect_eq("pre_reset_rx_valid", 64'(rx_valid), 64'd1);
        next_cycle();
        reset_n = 1'b0;
        next_cycle();
        @(negedge clk);
        expect_all_zero("reset_mid_stream");
        next_cycle();
        reset_n    = 1'b1;
        bus.stream = 1'b0;
        next_cycle();
        @(negedge clk);
        expect_eq("post_reset_rx_valid", 64'(rx_valid), 64'd0);
        expect_eq("final_rx_q_empty", 64'(rx_q.size()), 64'd0);
        expect_eq("final_start_q_empty", 64'(start_q.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/uarc_bus_receiver.md
Name: uarc_bus_receiver

Overview:
- Receiving endpoint of a UARC core-to-core bus; instantiated once per inbound bus on a core.
- Answers the kill / incept / send / stream request-acknowledge handshakes.
- Writes incepted programs into the core's program memory and queues sent or streamed data words in a FIFO for the core.
- Sender-side signals are sampled in this block's clock domain (synchronous design).

Parameters:
- WIDTH, 32, bus word width (data, permission, address).
- PROG_AW, 10, program memory address width; max program length is 2**PROG_AW words.
- FIFO_DEPTH, 8, receive FIFO entries; power of two, >=2.

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous active-low reset
- enabled  in  1  bus enabled by sender; when 0, all requests are ignored
- kill  in  1  kill request
- kill_ack  out  1  kill acknowledge
- incept  in  1  incept request; held high for the whole program transfer
- incept_ack  out  1  incept acknowledge; words transfer while incept and incept_ack are both high
- send  in  1  single-word send request
- send_ack  out  1  send acknowledge
- stream  in  1  stream request; held high for the whole stream
- stream_ack  out  1  stream acknowledge
- data  in  WIDTH  bus data word
- incept_permission  in  WIDTH  permission for the incepted program
- incept_address  in  WIDTH  start address for the incepted program
- core_busy  in  1  core is executing; incept is refused while high
- core_kill  out  1  one-cycle pulse that halts the core
- prog_we  out  1  program memory write enable
- prog_waddr  out  PROG_AW  program memory write address
- prog_wdata  out  WIDTH  program memory write data
- prog_start  out  1  one-cycle pulse: program loaded, start core
- prog_start_address  out  WIDTH  latched incept_address
- prog_permission  out  WIDTH  latched incept_permission
- incept_error  out  1  one-cycle pulse: program overflowed, start suppressed
- rx_valid  out  1  FIFO not empty
- rx_data  out  WIDTH  FIFO head word
- rx_is_stream  out  1  FIFO head word arrived via stream (0 means via send)
- rx_ready  in  1  core pops the head word when rx_valid and rx_ready

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state <= IDLE; FIFO emptied; word counter cleared.
  - All outputs 0, including latched prog_start_address and prog_permission.
- States: IDLE, KILL, INCEPT, STREAM.
- Request qualifier: req_X = enabled & X.
- Request priority in IDLE: kill > incept > stream > send.
- Kill:
  - req_kill in any state -> next cycle enters KILL.
  - In KILL, kill_ack=1 and core_kill=1 for exactly one cycle, then state returns to IDLE.
  - Entering KILL aborts INCEPT (no prog_start, no incept_error), aborts STREAM, and flushes the FIFO (same edge as entering KILL).
  - kill is not re-acknowledged until it has been sampled low for at least one cycle.
- Incept:
  - In IDLE, req_incept & !core_busy & !req_kill -> INCEPT, and counter <= 0.
  - incept_ack is registered; it is 1 throughout INCEPT.
  - Each cycle in INCEPT with incept=1 transfers one word: prog_we=1, prog_waddr=counter, prog_wdata=data (combinational from data); counter increments.
  - The first word transfers in the first cycle incept_ack is high.
  - On the first transfer, incept_address and incept_permission are latched to prog_start_address and prog_permission.
  - Counter saturates at 2**PROG_AW. Words beyond that are acknowledged but not written (prog_we=0), and an overflow flag is set.
  - Sampled incept=0 or enabled=0 in INCEPT -> IDLE next cycle with incept_ack=0.
    - If at least one word was received and there is no overflow: prog_start pulses on that same cycle.
    - If overflow: incept_error pulses instead.
    - If zero words were received: no pulse.
- Stream:
  - In IDLE, req_stream & !req_kill & !req_incept -> STREAM.
  - stream_ack = (state==STREAM) & !fifo_full, combinational.
  - A word pushes when stream & stream_ack; rx_is_stream=1 for that entry.
  - Sampled stream=0 or enabled=0 in STREAM -> IDLE next cycle.
- Send:
  - send_ack = (state==IDLE) & req_send & !req_kill & !req_incept & !req_stream & !fifo_full, combinational; same-cycle acknowledge is allowed.
  - Word pushes when send_ack=1; rx_is_stream=0.
- FIFO:
  - Registered storage; rx_data and rx_is_stream show the head entry.
  - Push and pop may occur in the same cycle; count is unchanged.
  - fifo_full is based on the registered count: when full, a same-cycle pop does not enable a push.
  - A pop while empty has no effect.
- enabled=0: no new acknowledges are issued. Any active INCEPT or STREAM terminates as described above. The FIFO contents are retained.

Test Plan:
- Incept of 4 words (0xA0..0xA3), incept_address=0x100, incept_permission=0x7 -> incept_ack high 1 cycle after request; prog_we at addresses 0..3; incept falls -> prog_start pulses once with prog_start_address=0x100 and prog_permission=0x7.
- send with data=0x55 while FIFO empty, rx_ready=0 -> send_ack in the same cycle; rx_valid=1, rx_data=0x55, rx_is_stream=0 next cycle.
- Stream of 10 words, FIFO_DEPTH=8, rx_ready=0 -> 8 words accepted and stream_ack drops. Then rx_ready=1 -> remaining 2 accepted in order; rx_data sequence matches the input and every word has rx_is_stream=1.
- kill asserted on the 3rd word of an incept -> kill_ack and core_kill each high exactly 1 cycle; no prog_start, no incept_error; FIFO empty; kill held high afterwards gives no second ack.
- incept while core_busy=1 -> incept_ack stays 0. Simultaneous incept and stream in IDLE -> incept wins and stream_ack stays 0.
- PROG_AW=2 with 5 incept words -> 4 writes (addresses 0..3), the 5th is acknowledged but not written, incept_error pulses, prog_start stays 0. Also: reset_n low mid-stream -> all outputs 0 and rx_valid=0 on the next edge.
